// File: rtl/quick_spi_pkg.sv
// Shared state encoding and mode-vector bit positions for the quick_spi_mc master.
package quick_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4,
        ST_LINGER = 3'd5,
        ST_GAP    = 3'd6
    } state_e;

    // Latched per-word mode vector layout
    localparam int unsigned MODE_CPHA = 0;
    localparam int unsigned MODE_CPOL = 1;
    localparam int unsigned MODE_LSB  = 2;
    localparam int unsigned MODE_W    = 3;

endpackage

// File: rtl/quick_spi_clkgen.sv
// Half-period timer: strobes at the end of each half period and classifies
// SCLK edges as leading/trailing while shifting.
module quick_spi_clkgen #(
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned EDGE_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic                 shift_en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 hp_end_c,
    output logic                 lead_c,
    output logic                 trail_c,
    output logic                 last_edge_c
);

    localparam int unsigned EDGE_W = $clog2(EDGE_COUNT);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [EDGE_W-1:0]    edge_q;

    assign hp_end_c    = (cnt_q == div);
    assign lead_c      = hp_end_c & shift_en & ~edge_q[0];
    assign trail_c     = hp_end_c & shift_en & edge_q[0];
    assign last_edge_c = (edge_q == EDGE_W'(EDGE_COUNT - 1));

    // Both counters restart on every state entry so each state owns whole half periods
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            edge_q <= '0;
        end else if (restart) begin
            cnt_q  <= '0;
            edge_q <= '0;
        end else begin
            if (hp_end_c) cnt_q <= '0;
            else          cnt_q <= cnt_q + DIV_WIDTH'(1);
            if (hp_end_c && shift_en) edge_q <= edge_q + EDGE_W'(1);
        end
    end

endmodule

// File: rtl/quick_spi_mc.sv
// Multi-mode SPI master: one full-duplex word per start, selectable CPOL/CPHA,
// bit order and rate, with optional slave-select hold across burst words.
module quick_spi_mc
    import quick_spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SLAVE_COUNT = 2,
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned SEL_WIDTH   = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SEL_WIDTH-1:0]   slave,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic                   lsb_first,
    input  logic [DIV_WIDTH-1:0]   clk_div,
    input  logic                   keep_ss,
    input  logic                   ss_release,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    output logic [DATA_WIDTH-1:0]  rx_data,
    output logic                   ready,
    output logic                   done,
    output logic                   error,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [SLAVE_COUNT-1:0] ss_n
);

    state_e                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   slave_q;
    logic [MODE_W-1:0]      mode_q, mode_in;
    logic [DIV_WIDTH-1:0]   div_q;
    logic                   keep_q;
    logic                   gap_setup_q;
    logic [DATA_WIDTH-1:0]  tx_sr, rx_sr;
    logic                   bit_q;
    logic                   sclk_q;
    logic                   samp_q;

    logic                   accept_c, reject_c, restart_c, slave_ok_c;
    logic                   hp_end_c, lead_c, trail_c, last_edge_c;
    logic                   sample_c, drive_c;
    logic [SLAVE_COUNT-1:0] sel_c, ss_c;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign mode_in[MODE_CPHA] = cpha;
    assign mode_in[MODE_CPOL] = cpol;
    assign mode_in[MODE_LSB]  = lsb_first;

    assign slave_ok_c = ({1'b0, slave} < (SEL_WIDTH + 1)'(SLAVE_COUNT));
    assign restart_c  = (state_d != state_q);
    assign sample_c   = mode_q[MODE_CPHA] ? trail_c : lead_c;
    assign drive_c    = mode_q[MODE_CPHA] ? lead_c  : trail_c;

    quick_spi_clkgen #(
        .DIV_WIDTH  (DIV_WIDTH),
        .EDGE_COUNT (2 * DATA_WIDTH)
    ) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (restart_c),
        .shift_en    (state_q == ST_SHIFT),
        .div         (div_q),
        .hp_end_c    (hp_end_c),
        .lead_c      (lead_c),
        .trail_c     (trail_c),
        .last_edge_c (last_edge_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        reject_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (slave_ok_c) begin
                        accept_c = 1'b1;
                        state_d  = ST_SETUP;
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end
            ST_SETUP:  if (hp_end_c) state_d = ST_SHIFT;
            ST_SHIFT:  if (hp_end_c && last_edge_c) state_d = ST_HOLD;
            ST_HOLD:   if (hp_end_c) state_d = ST_DONE;
            ST_DONE:   state_d = keep_q ? ST_LINGER : ST_IDLE;
            ST_LINGER: begin
                // A start outranks a simultaneous release
                if (start) begin
                    if (!slave_ok_c) begin
                        reject_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        state_d  = (slave == slave_q) ? ST_SHIFT : ST_GAP;
                    end
                end else if (ss_release) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:    if (hp_end_c) state_d = gap_setup_q ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_c = '0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (slave_q == SEL_WIDTH'(i)) sel_c[i] = 1'b1;
        end
    end

    always_comb begin
        ss_c = '1;
        case (state_q)
            ST_SETUP, ST_SHIFT, ST_HOLD, ST_LINGER: ss_c = ~sel_c;
            ST_DONE:  if (keep_q) ss_c = ~sel_c;
            default:  ss_c = '1;
        endcase
    end

    // Word datapath; pins are registered one cycle behind the internal timing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slave_q     <= '0;
            mode_q      <= '0;
            div_q       <= '0;
            keep_q      <= 1'b0;
            gap_setup_q <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_q       <= 1'b0;
            sclk_q      <= 1'b0;
            samp_q      <= 1'b0;
            ss_n        <= '1;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            rx_data     <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            ready       <= 1'b1;
        end else begin
            if (state_q == ST_LINGER) gap_setup_q <= accept_c;

            if (accept_c) begin
                slave_q <= slave;
                mode_q  <= mode_in;
                div_q   <= clk_div;
                keep_q  <= keep_ss;
                sclk_q  <= cpol;
                if (!cpha) begin
                    bit_q <= first_bit(tx_data, lsb_first);
                    tx_sr <= shift_out(tx_data, lsb_first);
                end else begin
                    tx_sr <= tx_data;
                end
            end else begin
                if (drive_c) begin
                    bit_q <= first_bit(tx_sr, mode_q[MODE_LSB]);
                    tx_sr <= shift_out(tx_sr, mode_q[MODE_LSB]);
                end
                if (state_q == ST_SHIFT && hp_end_c) sclk_q <= ~sclk_q;
            end

            samp_q <= sample_c;
            if (samp_q) begin
                if (mode_q[MODE_LSB]) rx_sr <= {miso, rx_sr[DATA_WIDTH-1:1]};
                else                  rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
            end

            ss_n  <= ss_c;
            sclk  <= sclk_q;
            mosi  <= bit_q;
            done  <= (state_q == ST_DONE);
            error <= reject_c;
            ready <= (state_d == ST_IDLE) || (state_d == ST_LINGER);
            if (state_q == ST_DONE) rx_data <= rx_sr;
        end
    end

endmodule

// File: tb/tb_quick_spi_mc.sv
// Directed bench for quick_spi_mc: modes, bit order, burst hold, rejects and mid-word reset.
module tb_quick_spi_mc;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] slave;
    logic       cpol, cpha, lsb_first;
    logic [7:0] clk_div;
    logic       keep_ss, ss_release;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       ready, done, error, sclk, mosi, miso;
    logic [1:0] ss_n;

    int n_assert = 0;
    int n_fail   = 0;

    logic       loop_en;
    logic       slave_en;
    logic       s_cpol;
    logic [7:0] s_pat;
    logic [7:0] s_rx;
    logic       miso_s;
    int         s_idx;
    time        t_prev, t_last;

    quick_spi_mc #(
        .DATA_WIDTH  (8),
        .SLAVE_COUNT (2),
        .DIV_WIDTH   (8),
        .SEL_WIDTH   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .slave      (slave),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsb_first  (lsb_first),
        .clk_div    (clk_div),
        .keep_ss    (keep_ss),
        .ss_release (ss_release),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .ready      (ready),
        .done       (done),
        .error      (error),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .ss_n       (ss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb miso = loop_en ? mosi : miso_s;

    // CPHA=1 slave: drive on leading SCLK edges, capture on trailing edges
    always @(sclk) begin
        if (!slave_en) begin
            s_idx = 0;
        end else begin
            t_prev = t_last;
            t_last = $time;
            if (sclk != s_cpol) begin
                if (s_idx < 8) miso_s = s_pat[7 - s_idx];
                s_idx = s_idx + 1;
            end else begin
                s_rx = {s_rx[6:0], mosi};
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one word and wait (bounded) for done; report what the pins showed after start
    task automatic run_word(input logic [1:0] sl, input logic pol, input logic pha,
                            input logic lsb, input logic [7:0] div, input logic keep,
                            input logic [7:0] data, output int lat,
                            output logic [1:0] ss1, output logic mosi1,
                            output logic sclk1, output logic rdy1, output logic ss_hi);
        slave     = sl;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        clk_div   = div;
        keep_ss   = keep;
        tx_data   = data;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        tx_data = ~data;
        lat     = 0;
        ss_hi   = 1'b0;
        ss1     = 2'bxx;
        mosi1   = 1'bx;
        sclk1   = 1'bx;
        rdy1    = 1'bx;
        while (!done && lat < 400) begin
            tick();
            lat++;
            if (lat == 1) begin
                ss1   = ss_n;
                mosi1 = mosi;
                sclk1 = sclk;
                rdy1  = ready;
            end
            if (!done && ss_n == 2'b11) ss_hi = 1'b1;
        end
    endtask

    initial begin
        int         lat;
        logic [1:0] ss1;
        logic       mosi1, sclk1, rdy1, ss_hi, bad;

        rst_n = 1'b0; start = 1'b0; slave = '0; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; clk_div = '0; keep_ss = 1'b0; ss_release = 1'b0;
        tx_data = '0; loop_en = 1'b1; slave_en = 1'b0; s_cpol = 1'b0; s_pat = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_ss_n",  32'(ss_n),    32'h3);
        check("rst_sclk",  32'(sclk),    32'h0);
        check("rst_mosi",  32'(mosi),    32'h0);
        check("rst_rx",    32'(rx_data), 32'h0);
        check("rst_done",  32'(done),    32'h0);
        check("rst_error", 32'(error),   32'h0);
        check("rst_ready", 32'(ready),   32'h1);

        // Mode 0, fastest rate, loopback
        run_word(2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'hA5, lat, ss1, mosi1, sclk1, rdy1, ss_hi);
        check("m0_ss_sel",  32'(ss1),     32'h2);
        check("m0_mosi1",   32'(mosi1),   32'h1);
        check("m0_sclk1",   32'(sclk1),   32'h0);
        check("m0_busy",    32'(rdy1),    32'h0);
        check("m0_latency", 32'(lat),     32'd19);
        check("m0_rx",      32'(rx_data), 32'hA5);
        check("m0_ss_end",  32'(ss_n),    32'h3);
        check("m0_ready",   32'(ready),   32'h1);
        tick();
        check("m0_done_1cy", 32'(done),   32'h0);

        // Mode 3, H=4, external slave
        loop_en  = 1'b0;
        s_cpol   = 1'b1;
        s_pat    = 8'h3C;
        slave_en = 1'b1;
        run_word(2'd0, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'hC3, lat, ss1, mosi1, sclk1, rdy1, ss_hi);
        slave_en = 1'b0;
        loop_en  = 1'b1;
        check("m3_sclk_idle", 32'(sclk1),          32'h1);
        check("m3_latency",   32'(lat),            32'd73);
        check("m3_slave_rx",  32'(s_rx),           32'hC3);
        check("m3_rx",        32'(rx_data),        32'h3C);
        check("m3_half_per",  32'(t_last - t_prev), 32'd40);
        check("m3_sclk_end",  32'(sclk),           32'h1);

        // LSB first
        run_word(2'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'h01, lat, ss1, mosi1, sclk1, rdy1, ss_hi);
        check("lsb_mosi1", 32'(mosi1),   32'h1);
        check("lsb_rx",    32'(rx_data), 32'h01);
        check("lsb_lat",   32'(lat),     32'd19);

        // Two-word burst to slave 1 with select held
        run_word(2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h11, lat, ss1, mosi1, sclk1, rdy1, ss_hi);
        check("b1_ss_sel", 32'(ss1),     32'h1);
        check("b1_lat",    32'(lat),     32'd19);
        check("b1_rx",     32'(rx_data), 32'h11);
        check("b1_ss_hold", 32'(ss_n),   32'h1);
        check("b1_ready",  32'(ready),   32'h1);
        check("b1_ss_hi",  32'(ss_hi),   32'h0);
        run_word(2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h22, lat, ss1, mosi1, sclk1, rdy1, ss_hi);
        check("b2_ss_sel", 32'(ss1),     32'h1);
        check("b2_lat",    32'(lat),     32'd18);
        check("b2_rx",     32'(rx_data), 32'h22);
        check("b2_ss_hi",  32'(ss_hi),   32'h0);
        tick();
        check("b2_linger_ss", 32'(ss_n), 32'h1);
        ss_release = 1'b1;
        tick();
        ss_release = 1'b0;
        check("rel_busy",  32'(ready), 32'h0);
        tick();
        check("rel_ss_n",  32'(ss_n),  32'h3);
        check("rel_ready", 32'(ready), 32'h1);

        // Out-of-range slave
        slave   = 2'd2;
        tx_data = 8'h77;
        keep_ss = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", 32'(error), 32'h1);
        check("err_ready", 32'(ready), 32'h1);
        tick();
        check("err_clear", 32'(error), 32'h0);
        bad = 1'b0;
        repeat (30) begin
            tick();
            if (done || ss_n != 2'b11) bad = 1'b1;
        end
        check("err_quiet", 32'(bad), 32'h0);

        // Reset in cycle 8 of a word
        slave     = 2'd0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsb_first = 1'b0;
        clk_div   = 8'd0;
        tx_data   = 8'hFF;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("mid_sclk_pre", 32'(sclk), 32'h1);
        rst_n = 1'b0;
        tick();
        check("mid_ss_n",  32'(ss_n),    32'h3);
        check("mid_sclk",  32'(sclk),    32'h0);
        check("mid_mosi",  32'(mosi),    32'h0);
        check("mid_done",  32'(done),    32'h0);
        check("mid_ready", 32'(ready),   32'h1);
        check("mid_rx",    32'(rx_data), 32'h0);
        rst_n = 1'b1;
        bad   = 1'b0;
        repeat (30) begin
            tick();
            if (done || ss_n != 2'b11) bad = 1'b1;
        end
        check("mid_quiet", 32'(bad), 32'h0);
        run_word(2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h5A, lat, ss1, mosi1, sclk1, rdy1, ss_hi);
        check("post_lat", 32'(lat),     32'd19);
        check("post_rx",  32'(rx_data), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
